// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, two prioritised write ports,
// r0 hardwired to zero, a hardware clear sweep and a per-register busy scoreboard.
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr_req,
   output logic                     ready,
   input  logic                     wr0_en,
   input  logic [ADDR_W-1:0]        wr0_addr,
   input  logic [DATA_W-1:0]        wr0_data,
   input  logic                     wr1_en,
   input  logic [ADDR_W-1:0]        wr1_addr,
   input  logic [DATA_W-1:0]        wr1_data,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic {CLEAR, RUN} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   idx;
   logic [DEPTH-1:0]    busy;
   logic [DATA_W-1:0]   regs [DEPTH];

   logic wr0_ok, wr1_ok, rsv_ok;

   assign wr0_ok = (state == RUN) && wr0_en && (wr0_addr != '0);
   assign wr1_ok = (state == RUN) && wr1_en && (wr1_addr != '0);
   assign rsv_ok = (state == RUN) && rsv_en && (rsv_addr != '0);

   // Control state, sweep index and scoreboard.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CLEAR;
         idx   <= ADDR_W'(1);
         busy  <= '0;
         ready <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               if (idx == '1) begin
                  state <= RUN;
                  ready <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            RUN: begin
               if (clr_req) begin
                  state <= CLEAR;
                  idx   <= ADDR_W'(1);
                  busy  <= '0;
                  ready <= 1'b0;
               end else begin
                  // Reserve is applied last so it wins over a same-address write.
                  if (wr0_ok) busy[wr0_addr] <= 1'b0;
                  if (wr1_ok) busy[wr1_addr] <= 1'b0;
                  if (rsv_ok) busy[rsv_addr] <= 1'b1;
               end
            end
            default: state <= CLEAR;
         endcase
      end
   end

   // NOTE: the storage array has no reset; the clear sweep zeroes it and reads are
   // forced to zero until the sweep completes, so a reset net here would be pure cost.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         regs[idx] <= '0;
      end else begin
         if (wr0_ok) regs[wr0_addr] <= wr0_data;
         if (wr1_ok) regs[wr1_addr] <= wr1_data;
      end
   end

   // NOTE: combinational outputs get defaults first and use blocking assignments,
   // so no path through the loop can leave a latch behind.
   always_comb begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      rd_data = '0;
      rd_busy = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         a = rd_addr[k*ADDR_W +: ADDR_W];
         d = '0;
         if (state == RUN && a != '0) begin
            d = regs[a];
`ifdef REGFILE_BYPASS_EN
            if (wr0_ok && wr0_addr == a) d = wr0_data;
            if (wr1_ok && wr1_addr == a) d = wr1_data;
`endif
            rd_busy[k] = busy[a];
         end
         rd_data[k*DATA_W +: DATA_W] = d;
      end
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file: the next-generation general-purpose register bank for the RISC datapath. It provides `NUM_RD` combinational read ports and two write ports with fixed priority, and keeps register 0 hardwired to zero. It includes a hardware clear sequencer that zeroes the array after reset or on request, and a per-register scoreboard of pending-write busy bits used by issue logic for hazard detection.

## Interface
- `DATA_W`, 32: register width in bits.
- `ADDR_W`, 5: address width; depth `DEPTH = 2**ADDR_W`.
- `NUM_RD`, 2: number of read ports (1..8).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `clr_req`  in  1  request a full clear sweep; sampled only in RUN.
- `ready`  out  1  high in RUN; low during the clear sweep.
- `wr0_en`, `wr1_en`  in  1  write enables.
- `wr0_addr`, `wr1_addr`  in  ADDR_W  write addresses.
- `wr0_data`, `wr1_data`  in  DATA_W  write data.
- `rsv_en`  in  1  mark a register busy (pending producer issued).
- `rsv_addr`  in  ADDR_W  register to reserve.
- `rd_addr`  in  NUM_RD*ADDR_W  flattened read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- `rd_data`  out  NUM_RD*DATA_W  flattened read data, combinational.
- `rd_busy`  out  NUM_RD  busy bit of each read port's register, combinational.

## Operation
- FSM states: CLEAR and RUN.
- While `rst` is high: state = CLEAR, sweep index = 1, all busy bits = 0.
- CLEAR sweep:
  - Each cycle writes 0 to `regs[idx]` and increments `idx`.
  - After writing `DEPTH-1`, the FSM moves to RUN.
  - Write ports, `rsv_en` and `clr_req` are ignored during CLEAR.
- RUN: `clr_req`=1 moves to CLEAR with `idx`=1 and clears all busy bits on that edge. Writes in that same cycle are still performed.
- Writes (RUN only): a port with `en`=1 and `addr`!=0 updates `regs[addr]`. If both ports target the same address, port 1's data is stored.
- Register 0 always reads 0 and is never busy. Writes and reservations to address 0 are dropped.
- Scoreboard (RUN only):
  - `rsv_en` sets `busy[rsv_addr]`.
  - Any accepted write clears `busy[wr_addr]`.
  - If a reserve and a write hit the same address in the same cycle, the reserve wins (busy stays 1).
- Read port k:
  - Returns 0 if the address is 0 or the state is CLEAR.
  - Otherwise returns the forwarded value (see Configuration) or `regs[addr]`.
  - `rd_busy[k]` = `busy[addr]`, and is 0 during CLEAR.
- Arithmetic: `idx` is ADDR_W bits wide; the terminal compare is against all-ones, so there is no wrap.

## Timing
- Reset values: `ready`=0; `rd_data`=0 and `rd_busy`=0 on every port (CLEAR forces zero).
- Clear sweep length: exactly `DEPTH-1` cycles after `rst` deasserts (31 for the defaults). `ready` rises on the edge that writes the last entry.
- From the `clr_req` edge, `ready` is low for `DEPTH-1` cycles.
- Write latency: stored at the rising edge and visible on reads from the following cycle (same cycle if forwarding is compiled in).
- Busy set/clear takes effect from the cycle after the edge.
- `rst` asserted mid-sweep or mid-operation restarts the sweep from `idx`=1 immediately (asynchronous).

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - In RUN, a read whose nonzero address matches an enabled write port in the same cycle returns that port's write data.
  - Port 1 takes priority over port 0 on a double match.
  - `rd_busy` still reflects the registered busy bit.
- Not defined: reads return the registered array contents only. A same-cycle write is seen one cycle later.

## Test plan
- Reset then release: `ready`=0 for exactly 31 cycles, then 1; every read returns 0 and `rd_busy`=0 throughout.
- RUN: `wr0` to r5 = 0xDEADBEEF, read r5 next cycle → 0xDEADBEEF. `wr1` to r0 = 0x1 → r0 reads 0.
- Same-cycle dual write to r7: `wr0`=0x11, `wr1`=0x22 → r7 = 0x22. With `REGFILE_BYPASS_EN`, a read of r7 in that cycle returns 0x22; without it, the read returns the old value.
- Scoreboard:
  - `rsv_en` r9 → `rd_busy`=1 next cycle.
  - A write to r9 → busy=0 next cycle.
  - Reserve and write to r9 in the same cycle → busy remains 1.
- `clr_req` after filling r1..r31 with 0xA5A5A5A5 and reserving r3 → `ready` low for 31 cycles. Afterwards all reads are 0 and r3 is not busy.
- `rst` pulsed at sweep `idx`=10 → sweep restarts; `ready` rises 31 cycles after release.
